// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with a registered one-hot grant
// and a per-grant hold limit. The search for the next owner starts one past
// the last granted index, so every active requester is served in turn.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid
);

    // Hold counter width, derived from MAX_HOLD so that MAX_HOLD itself fits.
    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_ONE = CW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state_q;
    logic [7:0]    gnt_q;
    logic [2:0]    gnt_idx_q;
    logic          gnt_valid_q;
    logic [2:0]    ptr_q;
    logic [CW-1:0] hold_q;

    logic          sel_found;
    logic [2:0]    sel_idx;
    logic [2:0]    cand;
    logic [7:0]    gnt_d;
    logic [2:0]    ptr_d;
    logic          release_w;

    // Pick the first requester at or after the pointer, wrapping modulo 8.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        cand      = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // 3-to-8 decode of the selected index, enabled only when a candidate exists.
    always_comb begin
        gnt_d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            gnt_d[i] = sel_found && (sel_idx == 3'(i));
        end
        ptr_d = sel_idx + 3'd1;
    end

    // The current owner lets go when it drops its request or uses up its hold.
    assign release_w = !req[gnt_idx_q] || (hold_q == HOLD_MAX);

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 8'h00;
            gnt_idx_q   <= 3'd0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= 3'd0;
            hold_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en && sel_found) begin
                        state_q     <= BUSY;
                        gnt_q       <= gnt_d;
                        gnt_idx_q   <= sel_idx;
                        gnt_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        hold_q      <= HOLD_ONE;
                    end
                end
                BUSY: begin
                    if (!release_w) begin
                        hold_q <= hold_q + HOLD_ONE;
                    end else if (en && sel_found) begin
                        // Back-to-back handover with no idle cycle in between.
                        gnt_q       <= gnt_d;
                        gnt_idx_q   <= sel_idx;
                        gnt_valid_q <= 1'b1;
                        ptr_q       <= ptr_d;
                        hold_q      <= HOLD_ONE;
                    end else begin
                        state_q     <= IDLE;
                        gnt_q       <= 8'h00;
                        gnt_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    gnt_q       <= 8'h00;
                    gnt_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;

    int n_tests;
    int n_fail;

    // Behavioural model state: current owner, next search start, cycles held.
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_hold;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, update the model with the inputs seen at that
    // edge, then move 1 time unit past the edge so outputs can be sampled.
    task automatic tick();
        bit rel;
        int pick;
        int c;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
            m_hold  = 0;
        end else begin
            rel = m_valid ? (!req[m_idx] || (m_hold == MAX_HOLD)) : 1'b1;
            if (!rel) begin
                m_hold = m_hold + 1;
            end else begin
                pick = -1;
                if (en) begin
                    for (int k = 0; k < 8; k++) begin
                        c = (m_ptr + k) % 8;
                        if (pick < 0 && req[c]) pick = c;
                    end
                end
                if (pick >= 0) begin
                    m_valid = 1'b1;
                    m_idx   = pick;
                    m_ptr   = (pick + 1) % 8;
                    m_hold  = 1;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        req = 8'h00;
        tick();
        tick();
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: gnt=%h valid=%b idx=%0d, expected gnt=00 valid=0 idx=0",
                     gnt, gnt_valid, gnt_idx);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        req = 8'h10;
        tick();
        n_tests++;
        if (gnt !== 8'h10 || gnt_idx !== 3'd4 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: gnt=%h idx=%0d valid=%b, expected gnt=10 idx=4 valid=1",
                     gnt, gnt_idx, gnt_valid);
        end
        tick();
        n_tests++;
        if (gnt !== 8'h10) begin
            n_fail++;
            $display("FAIL single_hold: gnt=%h, expected 10", gnt);
        end
        req = 8'h00;
        tick();
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: gnt=%h valid=%b, expected gnt=00 valid=0", gnt, gnt_valid);
        end
        // Pointer should now be 5: with requests on 0 and 5, index 5 wins.
        req = 8'h21;
        tick();
        n_tests++;
        if (gnt_idx !== 3'd5 || gnt !== 8'h20) begin
            n_fail++;
            $display("FAIL single_ptr: idx=%0d gnt=%h, expected idx=5 gnt=20", gnt_idx, gnt);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_rotation();
        int exp_idx;
        int bad;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 8'hFF;
        bad = 0;
        for (int c = 1; c <= 36; c++) begin
            tick();
            exp_idx = ((c - 1) / MAX_HOLD) % 8;
            if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_idx) || gnt !== (8'h01 << exp_idx)) begin
                if (bad < 4)
                    $display("FAIL rotation: cycle %0d gnt=%h idx=%0d valid=%b, expected idx=%0d valid=1",
                             c, gnt, gnt_idx, gnt_valid, exp_idx);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        req = 8'h40;
        tick();
        n_tests++;
        if (gnt_idx !== 3'd6 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_setup: idx=%0d valid=%b, expected idx=6 valid=1", gnt_idx, gnt_valid);
        end
        req = 8'h05;
        tick();
        n_tests++;
        if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin
            n_fail++;
            $display("FAIL wrap_to_0: idx=%0d gnt=%h, expected idx=0 gnt=01", gnt_idx, gnt);
        end
        for (int i = 0; i < MAX_HOLD - 1; i++) tick();
        tick();
        n_tests++;
        if (gnt_idx !== 3'd2 || gnt !== 8'h04 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_skip: idx=%0d gnt=%h valid=%b, expected idx=2 gnt=04 valid=1",
                     gnt_idx, gnt, gnt_valid);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        int bad;
        bad = 0;
        req = 8'h08;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (gnt_idx !== 3'd3 || gnt_valid !== 1'b1 || gnt !== 8'h08) begin
                if (bad < 4)
                    $display("FAIL timeout_sole: cycle %0d gnt=%h idx=%0d valid=%b, expected gnt=08 idx=3 valid=1",
                             c, gnt, gnt_idx, gnt_valid);
                bad++;
            end
        end
        n_tests++;
        if (bad != 0) n_fail++;
        req = 8'h00;
        tick();
    endtask

    task automatic test_enable();
        int bad;
        req = 8'h02;
        tick();
        req = 8'h06;
        en  = 1'b0;
        bad = 0;
        for (int c = 0; c < MAX_HOLD - 1; c++) begin
            tick();
            if (gnt !== 8'h02 || gnt_valid !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL enable_hold: gnt=%h valid=%b, expected gnt=02 valid=1 for %0d cycles",
                     gnt, gnt_valid, MAX_HOLD);
        end
        tick();
        tick();
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_block: gnt=%h valid=%b, expected gnt=00 valid=0", gnt, gnt_valid);
        end
        en = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 8'h04 || gnt_idx !== 3'd2) begin
            n_fail++;
            $display("FAIL enable_resume: gnt=%h idx=%0d, expected gnt=04 idx=2", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_reset_mid();
        req = 8'h20;
        tick();
        n_tests++;
        if (gnt !== 8'h20) begin
            n_fail++;
            $display("FAIL rstmid_setup: gnt=%h, expected 20", gnt);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: gnt=%h valid=%b, expected gnt=00 valid=0", gnt, gnt_valid);
        end
        rst = 1'b0;
        req = 8'hFF;
        tick();
        n_tests++;
        if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
            n_fail++;
            $display("FAIL rstmid_next: gnt=%h idx=%0d, expected gnt=01 idx=0", gnt, gnt_idx);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] exp_gnt;
        int bad;
        bad = 0;
        for (int c = 0; c < 600; c++) begin
            // Keep request patterns sticky for a few cycles so grants can complete.
            if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 99) == 0);
            tick();
            exp_gnt = m_valid ? (8'h01 << m_idx) : 8'h00;
            if (gnt !== exp_gnt || gnt_valid !== m_valid ||
                (m_valid && gnt_idx !== 3'(m_idx))) begin
                if (bad < 5)
                    $display("FAIL random: cycle %0d gnt=%h idx=%0d valid=%b, expected gnt=%h idx=%0d valid=%b",
                             c, gnt, gnt_idx, gnt_valid, exp_gnt, m_idx, m_valid);
                bad++;
            end
            if (!$onehot0(gnt)) bad++;
        end
        n_tests++;
        if (bad != 0) n_fail++;
        rst = 1'b0;
        req = 8'h00;
        en  = 1'b1;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_hold  = 0;
        rst = 1'b1;
        en  = 1'b1;
        req = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_timeout();
        test_enable();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
8-way round-robin arbiter that shares one resource among eight requesters. It issues a registered one-hot grant, formed by decoding a 3-bit grant index gated by a valid enable (3-to-8 decode with enable). It also enforces a per-grant hold limit so that no requester can starve the others. It sits between the requesters and the shared datapath and drives that datapath's select lines.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one grant may last; legal range 1..256
CW, $clog2(MAX_HOLD)+1, width of the internal hold counter (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  arbitration enable; 0 blocks new grants, current grant may complete
req  input  8  request vector; requester i holds req[i]=1 for as long as it needs the resource
gnt  output  8  one-hot grant; all zero when gnt_valid=0
gnt_idx  output  3  index of the granted requester; valid only when gnt_valid=1
gnt_valid  output  1  a grant is active

Behaviour:
- All outputs are registered. Clock and reset are fixed: one clock, reset is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, pointer=3'd0, hold_cnt=0. Reset overrides everything, including an active grant; the grant drops at the same edge.
- gnt[i] = gnt_valid & (gnt_idx==i), at all times.
- Pointer ptr = the search start index. After any grant to index k, ptr = k+1 mod 8 (7 wraps to 0).
- Selection function: first i in the order ptr, ptr+1, ..., ptr+7 (mod 8) with req[i]=1.
- States:
  - IDLE: if en=1 and req!=0, then at the edge grant the selected index, set hold_cnt=1, go to BUSY. Otherwise stay in IDLE. Latency is 1 cycle from the first sampled request to gnt.
  - BUSY: a release condition exists when req[gnt_idx]=0 (voluntary release) or hold_cnt==MAX_HOLD (timeout).
    - No release: hold_cnt+1, and the grant is unchanged.
    - Release with en=1 and another qualifying request: back-to-back grant to the newly selected index, hold_cnt=1, stay in BUSY. There is no idle gap cycle.
    - Release otherwise: gnt_valid=0, go to IDLE.
- On timeout the current requester is still asserting. The search starts at gnt_idx+1, so it is re-granted only if no other requester is asserting; in that case it gets a fresh hold_cnt=1.
- Changes to req[j] for j != gnt_idx never disturb an active grant.
- en=0 during BUSY: the grant continues until release, then goes to IDLE. No new grant is issued until en=1.
- MAX_HOLD=1: every grant lasts exactly one cycle, and the arbiter rotates each cycle among the active requesters.
- hold_cnt never exceeds MAX_HOLD; no overflow is possible.
- At most one bit of gnt is ever set. gnt_valid=1 implies req[gnt_idx] was 1 at the granting edge.

Test Plan:
- Reset then single request: rst 2 cycles, req=8'h10 held -> gnt=8'h10, gnt_idx=4 one cycle after the first sampled req. Drop req after 2 granted cycles -> gnt=0 on the next edge, ptr=5.
- Rotation fairness: req=8'hFF continuously, MAX_HOLD=4 -> grants 0,1,2,...,7,0, each exactly 4 cycles, back-to-back with no gaps, gnt always one-hot.
- Wrap and skip: after a grant to index 6, req=8'h05 -> next grant is index 0, then index 2. Verify ptr wraps 7->0.
- Timeout, sole requester: req=8'h08 held 10 cycles, MAX_HOLD=4 -> gnt_idx stays 3, gnt_valid stays 1 throughout, hold_cnt restarts 1..4.
- Enable gating: BUSY on index 1 with req=8'h06, en=0 -> index 1 completes its hold, then gnt=0 and IDLE. Raise en -> grant to index 2 one cycle later.
- Reset mid-grant: gnt=8'h20 active, rst=1 for one cycle -> gnt=0 and gnt_valid=0 after that edge. Next grant with req=8'hFF goes to index 0.
